// File: rtl/conv5x5_window_ctrl.sv
// Purpose: raster-order pixel sequencer for the KxK window register array and line buffers.
// Latency: i_start -> o_ready 1 cycle; accept -> o_shift_en/o_win_valid/o_col/o_row/o_frame_done 1 cycle.
// Backpressure: o_ready stalls the source; with CONV_BACKPRESSURE_EN it is also gated by i_out_ready.
//
// Optional feature macro: CONV_BACKPRESSURE_EN (undefined by default; i_out_ready then ignored).
// State machine: IDLE -> RUN on i_start; RUN -> DONE on the accept of the last pixel;
// DONE -> IDLE unconditionally. i_start is ignored everywhere except IDLE.

module conv5x5_window_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_out_ready,
    output logic          o_shift_en,
    output logic [CW-1:0] o_lb_addr,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_win_valid,
    output logic          o_busy,
    output logic          o_frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wrap points and window thresholds, sized to the counters they are compared with.
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] WIN_COL  = CW'(K - 1);
    localparam logic [RW-1:0] WIN_ROW  = RW'(K - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] col_q;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_d;

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_full;

    logic          shift_q;
    logic          win_q;
    logic          done_q;
    logic [CW-1:0] col_out_q;
    logic [RW-1:0] row_out_q;

`ifdef CONV_BACKPRESSURE_EN
    // A downstream stall withholds ready so no further pixels are taken.
    assign o_ready = (state_q == ST_RUN) && i_out_ready;
`else
    // Downstream is assumed always able to absorb one window per cycle.
    logic unused_out_ready;
    assign unused_out_ready = i_out_ready;
    assign o_ready          = (state_q == ST_RUN);
`endif

    assign accept   = i_valid && o_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    // The pixel being accepted completes a KxK neighbourhood once K-1 columns
    // and K-1 rows precede it inside the image.
    assign win_full = (col_q >= WIN_COL) && (row_q >= WIN_ROW);

    // State and position counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next-state and counter update; counters wrap by compare so they never
    // exceed IMG_W-1 / IMG_H-1 even for non-power-of-two image sizes.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            ST_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered datapath controls: pulses follow the accept by one cycle,
    // position outputs hold their last value through gaps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q   <= 1'b0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
            col_out_q <= '0;
            row_out_q <= '0;
        end else begin
            shift_q <= accept;
            win_q   <= accept && win_full;
            done_q  <= accept && col_last && row_last;
            if (accept) begin
                col_out_q <= col_q;
                row_out_q <= row_q;
            end
        end
    end

    // Write and read of the line buffers share one column address.
    assign o_shift_en   = shift_q;
    assign o_win_valid  = win_q;
    assign o_frame_done = done_q;
    assign o_col        = col_out_q;
    assign o_lb_addr    = col_out_q;
    assign o_row        = row_out_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
